// File: rtl/mux_channel_scanner_if.sv
// Bus bundle between the channel scanner and its user / downstream 4:1 mux.
// sample_parity exists only when SCAN_PARITY_EN is defined.
interface mux_channel_scanner_if;
    logic       start;
    logic [3:0] chan_mask;
    logic       mux_in;
    logic [1:0] select;
    logic       busy;
    logic       done;
    logic [3:0] sample_data;
    logic [3:0] sample_valid;
`ifdef SCAN_PARITY_EN
    logic       sample_parity;

    modport master (
        output start, chan_mask, mux_in,
        input  select, busy, done, sample_data, sample_valid, sample_parity
    );
    modport slave (
        input  start, chan_mask, mux_in,
        output select, busy, done, sample_data, sample_valid, sample_parity
    );
`else
    modport master (
        output start, chan_mask, mux_in,
        input  select, busy, done, sample_data, sample_valid
    );
    modport slave (
        input  start, chan_mask, mux_in,
        output select, busy, done, sample_data, sample_valid
    );
`endif
endinterface

// File: rtl/mux_channel_scanner.sv
// Scans the masked channels of a downstream 4:1 mux in ascending order, settling each select
// before capturing its bit. Optional macro SCAN_PARITY_EN adds the sample_parity output.
module mux_channel_scanner #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_channel_scanner_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] mask_reg, mask_next;
    logic [1:0] select_reg, select_next;
    logic [3:0] data_reg, data_next;
    logic [3:0] valid_reg, valid_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic [3:0] higher_mask;
    logic       has_next;

    // Index of the lowest set bit; callers guarantee a non-zero argument.
    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Enabled channels strictly above the one currently selected.
    for (genvar gi = 0; gi < 4; gi++) begin : g_higher
        assign higher_mask[gi] = mask_reg[gi] && (2'(gi) > select_reg);
    end
    assign has_next = |higher_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) state_next = (bus.chan_mask == 4'd0) ? DONE : SETTLE;
            end
            SETTLE: begin
                if (cnt_reg <= 4'd1) state_next = SAMPLE;
            end
            SAMPLE: begin
                state_next = has_next ? SETTLE : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next    = cnt_reg;
        mask_next   = mask_reg;
        select_next = select_reg;
        data_next   = data_reg;
        valid_next  = valid_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mask_next  = bus.chan_mask;
                    data_next  = 4'd0;
                    valid_next = 4'd0;
                    cnt_next   = SETTLE_LOAD;
                    // An empty mask leaves select alone so no unmasked channel is driven.
                    if (bus.chan_mask != 4'd0) select_next = lowest_bit(bus.chan_mask);
                end
            end
            SETTLE: begin
                cnt_next = cnt_reg - 4'd1;
            end
            SAMPLE: begin
                data_next[select_reg]  = bus.mux_in;
                valid_next[select_reg] = 1'b1;
                if (has_next) begin
                    select_next = lowest_bit(higher_mask);
                    cnt_next    = SETTLE_LOAD;
                end
            end
            default: ;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= 4'd0;
            mask_reg   <= 4'd0;
            select_reg <= 2'd0;
            data_reg   <= 4'd0;
            valid_reg  <= 4'd0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            mask_reg   <= mask_next;
            select_reg <= select_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

`ifdef SCAN_PARITY_EN
    logic parity_reg;

    // Parity of the captured bits becomes visible together with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  parity_reg <= 1'b0;
        else if (state_next == DONE) parity_reg <= ^(data_next & valid_next);
    end
    assign bus.sample_parity = parity_reg;
`endif

    assign bus.select       = select_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.sample_data  = data_reg;
    assign bus.sample_valid = valid_reg;
endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboard bench for mux_channel_scanner: stimulus pushes expected scan results, a monitor
// pops and checks them on every done pulse. Parity is checked when SCAN_PARITY_EN is defined.
module tb_mux_channel_scanner;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] data_word = 4'd0;
    int ecount = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int         cyc;
        logic [3:0] sd;
        logic [3:0] sv;
        logic       par;
        int         len;
        logic [1:0] tr [12];
    } exp_t;

    exp_t sb[$];
    logic [1:0] trace[$];

    mux_channel_scanner_if bus();

    mux_channel_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Downstream 4:1 mux model.
    assign bus.mux_in = data_word[bus.select];

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, req);
        end
    endtask

    // Monitor: collects the select trace of the running scan and checks every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            trace.delete();
        end else begin
            if (bus.busy && !bus.done) trace.push_back(bus.select);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got=1 expected=0 at edge %0d", ecount);
                end else begin
                    exp_t e;
                    int tr_bad;
                    e = sb.pop_front();
                    check("done_cycle", ecount, e.cyc);
                    check("sample_data", int'(bus.sample_data), int'(e.sd));
                    check("sample_valid", int'(bus.sample_valid), int'(e.sv));
                    check("busy_in_done", int'(bus.busy), 1);
                    check("trace_len", trace.size(), e.len);
                    tr_bad = 0;
                    for (int i = 0; i < e.len && i < trace.size(); i++)
                        if (trace[i] !== e.tr[i]) tr_bad++;
                    check("select_trace_errs", tr_bad, 0);
`ifdef SCAN_PARITY_EN
                    check("sample_parity", int'(bus.sample_parity), int'(e.par));
`endif
                end
                trace.delete();
            end
        end
    end

    // Issue a start and push the expected result (sd/sv hand-computed by the caller).
    task automatic issue_scan(input logic [3:0] mask, input logic [3:0] data,
                              input logic [3:0] sd, input logic [3:0] sv);
        exp_t e;
        int n;
        @(negedge clk);
        bus.chan_mask = mask;
        data_word     = data;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0;
        e.len = 0;
        for (int i = 0; i < 12; i++) e.tr[i] = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) begin
                n++;
                for (int k = 0; k < S + 1; k++) begin
                    e.tr[e.len] = 2'(c);
                    e.len++;
                end
            end
        end
        e.cyc = ecount + n * (S + 1);
        e.sd  = sd;
        e.sv  = sv;
        e.par = ^(sd & sv);
        sb.push_back(e);
    endtask

    task automatic wait_scan(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_timeout"}, int'(sb.size() != 0), 0);
        sb.delete();
        @(negedge clk);
        check({name, "_busy_after"}, int'(bus.busy), 0);
        check({name, "_done_after"}, int'(bus.done), 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.chan_mask = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_select", int'(bus.select), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_sdata", int'(bus.sample_data), 0);
        check("rst_svalid", int'(bus.sample_valid), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All channels, alternating data.
        issue_scan(4'b1111, 4'b1010, 4'b1010, 4'b1111);
        wait_scan("full");
        repeat (3) @(negedge clk);
        check("hold_sdata", int'(bus.sample_data), 4'b1010);
        check("hold_svalid", int'(bus.sample_valid), 4'b1111);
        $display("scan mask=1111 data=1010 completed");

        // Sparse mask.
        issue_scan(4'b0101, 4'b1111, 4'b0101, 4'b0101);
        wait_scan("sparse");
        $display("scan mask=0101 data=1111 completed");

        // Empty mask goes straight to DONE.
        issue_scan(4'b0000, 4'b1111, 4'b0000, 4'b0000);
        wait_scan("empty");
        $display("scan mask=0000 completed");

        // Parity vector.
        issue_scan(4'b1111, 4'b1011, 4'b1011, 4'b1111);
        wait_scan("parity");
        $display("scan mask=1111 data=1011 completed");

        // Start and mask change while busy must be ignored.
        issue_scan(4'b1111, 4'b1010, 4'b1010, 4'b1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.chan_mask = 4'b0001;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_scan("repulse");
        repeat (20) @(negedge clk);
        $display("scan with start re-pulse completed");

        // Asynchronous reset mid-scan aborts without done.
        issue_scan(4'b1111, 4'b1010, 4'b1010, 4'b1111);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_select", int'(bus.select), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_sdata", int'(bus.sample_data), 0);
        check("arst_svalid", int'(bus.sample_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_restart", int'(bus.busy), 0);
        issue_scan(4'b1000, 4'b1000, 4'b1000, 4'b1000);
        wait_scan("after_reset");
        $display("scan after reset mask=1000 completed");

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
